// File: rtl/f8_regbank.sv
// Parametrised f8 register bank: NRD combinational read ports, byte-lane writes and,
// when F8_REGBANK_CTX_EN is defined, a spill/refill sequencer to data memory.
module f8_regbank #(
    parameter int NREGS  = 3,
    parameter int WIDTH  = 16,
    parameter int NRD    = 3,
    parameter int ADDR_W = 16,
    localparam int AW    = $clog2(NREGS),
    localparam int NB    = WIDTH / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NRD*AW-1:0]    rd_addr_i,
    output logic [NRD*WIDTH-1:0] rd_data_o,
    output logic [NRD*WIDTH-1:0] rd_next_o,
    input  logic [AW-1:0]        wr_addr_i,
    input  logic [WIDTH-1:0]     wr_data_i,
    input  logic [NB-1:0]        wr_en_i,
    input  logic                 ctx_save_i,
    input  logic                 ctx_restore_i,
    input  logic [ADDR_W-1:0]    ctx_base_i,
    output logic                 ctx_busy_o,
    output logic                 ctx_done_o,
    output logic                 mem_req_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [NB-1:0]        mem_we_o,
    output logic [WIDTH-1:0]     mem_wdata_o,
    input  logic [WIDTH-1:0]     mem_rdata_i,
    input  logic                 mem_ack_i
);

    localparam logic [AW:0]   NREGS_L = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    logic [WIDTH-1:0] regs_q [NREGS];

    logic          wr_addr_ok;
    logic          wr_ok;
    logic          rest_we;
    logic [AW-1:0] rest_idx;

    assign wr_addr_ok = ({1'b0, wr_addr_i} < NREGS_L);

`ifdef F8_REGBANK_CTX_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_SAVE,
        S_RESTORE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              busy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        case (state_q)
            S_IDLE: begin
                // Save has priority when both requests arrive together.
                if (ctx_save_i) begin
                    state_d = S_SAVE;
                    idx_d   = '0;
                    base_d  = ctx_base_i;
                end else if (ctx_restore_i) begin
                    state_d = S_RESTORE;
                    idx_d   = '0;
                    base_d  = ctx_base_i;
                end
            end
            S_SAVE, S_RESTORE: begin
                if (mem_ack_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == S_SAVE) || (state_q == S_RESTORE);
    assign ctx_busy_o  = busy;
    assign ctx_done_o  = (state_q == S_DONE);
    assign mem_req_o   = busy;
    assign mem_addr_o  = busy ? (base_q + ADDR_W'(idx_q) * ADDR_W'(NB)) : '0;
    assign mem_we_o    = (state_q == S_SAVE) ? {NB{1'b1}} : '0;
    assign mem_wdata_o = (state_q == S_SAVE) ? regs_q[idx_q] : '0;
    assign rest_we     = (state_q == S_RESTORE) && mem_ack_i;
    assign rest_idx    = idx_q;
    assign wr_ok       = wr_addr_ok && !busy;
`else
    logic unused_ctx;

    assign unused_ctx  = ^{ctx_save_i, ctx_restore_i, ctx_base_i, mem_ack_i};
    assign ctx_busy_o  = 1'b0;
    assign ctx_done_o  = 1'b0;
    assign mem_req_o   = 1'b0;
    assign mem_addr_o  = '0;
    assign mem_we_o    = '0;
    assign mem_wdata_o = '0;
    assign rest_we     = 1'b0;
    assign rest_idx    = '0;
    assign wr_ok       = wr_addr_ok;
`endif

    // Refill and user writes never coincide: user writes are blocked while busy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (rest_we && (rest_idx == AW'(r))) begin
                    regs_q[r] <= mem_rdata_i;
                end else if (wr_ok && (wr_addr_i == AW'(r))) begin
                    for (int k = 0; k < NB; k++) begin
                        if (wr_en_i[k]) begin
                            regs_q[r][8*k +: 8] <= wr_data_i[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    genvar gi, gl;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]    ra;
            logic             ra_ok;
            logic             hit;
            logic [WIDTH-1:0] cur;

            assign ra    = rd_addr_i[gi*AW +: AW];
            assign ra_ok = ({1'b0, ra} < NREGS_L);
            assign hit   = wr_ok && (wr_addr_i == ra);
            assign cur   = ra_ok ? regs_q[ra] : '0;
            assign rd_data_o[gi*WIDTH +: WIDTH] = cur;

            for (gl = 0; gl < NB; gl++) begin : g_lane
                assign rd_next_o[gi*WIDTH + 8*gl +: 8] =
                    (hit && wr_en_i[gl]) ? wr_data_i[8*gl +: 8] : cur[8*gl +: 8];
            end
        end
    endgenerate

endmodule

// File: tb/tb_f8_regbank.sv
// Randomized bench for f8_regbank against an array-based model of the register bank
// and a beat-by-beat expectation of the context sequencer (when F8_REGBANK_CTX_EN is set).
module tb_f8_regbank;

    localparam int NREGS  = 3;
    localparam int WIDTH  = 16;
    localparam int NRD    = 3;
    localparam int ADDR_W = 16;
    localparam int AW     = 2;
    localparam int NB     = 2;

    logic                 clk;
    logic                 rst_ni;
    logic [NRD*AW-1:0]    rd_addr_i;
    logic [NRD*WIDTH-1:0] rd_data_o;
    logic [NRD*WIDTH-1:0] rd_next_o;
    logic [AW-1:0]        wr_addr_i;
    logic [WIDTH-1:0]     wr_data_i;
    logic [NB-1:0]        wr_en_i;
    logic                 ctx_save_i;
    logic                 ctx_restore_i;
    logic [ADDR_W-1:0]    ctx_base_i;
    logic                 ctx_busy_o;
    logic                 ctx_done_o;
    logic                 mem_req_o;
    logic [ADDR_W-1:0]    mem_addr_o;
    logic [NB-1:0]        mem_we_o;
    logic [WIDTH-1:0]     mem_wdata_o;
    logic [WIDTH-1:0]     mem_rdata_i;
    logic                 mem_ack_i;

    f8_regbank #(
        .NREGS(NREGS), .WIDTH(WIDTH), .NRD(NRD), .ADDR_W(ADDR_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_next_o(rd_next_o),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_en_i(wr_en_i),
        .ctx_save_i(ctx_save_i), .ctx_restore_i(ctx_restore_i), .ctx_base_i(ctx_base_i),
        .ctx_busy_o(ctx_busy_o), .ctx_done_o(ctx_done_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] model [NREGS];
    int n_checks = 0;
    int n_errors = 0;

    // Expected sequencer-side outputs for the current cycle.
    logic              exp_busy, exp_done, exp_req;
    logic [ADDR_W-1:0] exp_addr;
    logic [NB-1:0]     exp_we;
    logic [WIDTH-1:0]  exp_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_rd(input int a);
        return (a < NREGS) ? model[a] : '0;
    endfunction

    task automatic exp_idle();
        exp_busy = 0; exp_done = 0; exp_req = 0;
        exp_addr = '0; exp_we = '0; exp_wdata = '0;
    endtask

    function automatic logic [WIDTH-1:0] port_data(input int p);
        return rd_data_o[p*WIDTH +: WIDTH];
    endfunction

    // Check all outputs mid-cycle, then advance one edge and update the model.
    task automatic cycle();
        bit               acc;
        int               a;
        logic [WIDTH-1:0] ed, en;
        @(negedge clk);
        acc = !exp_busy && (int'(wr_addr_i) < NREGS);
        for (int p = 0; p < NRD; p++) begin
            a  = int'(rd_addr_i[p*AW +: AW]);
            ed = model_rd(a);
            en = ed;
            for (int k = 0; k < NB; k++)
                if (acc && int'(wr_addr_i) == a && wr_en_i[k]) en[8*k +: 8] = wr_data_i[8*k +: 8];
            check($sformatf("rd_data[%0d]", p), rd_data_o[p*WIDTH +: WIDTH], ed);
            check($sformatf("rd_next[%0d]", p), rd_next_o[p*WIDTH +: WIDTH], en);
        end
        check("ctx_busy", ctx_busy_o, exp_busy);
        check("ctx_done", ctx_done_o, exp_done);
        check("mem_req", mem_req_o, exp_req);
        check("mem_addr", mem_addr_o, exp_addr);
        check("mem_we", mem_we_o, exp_we);
        check("mem_wdata", mem_wdata_o, exp_wdata);
        @(posedge clk);
        if (acc)
            for (int k = 0; k < NB; k++)
                if (wr_en_i[k]) model[wr_addr_i][8*k +: 8] = wr_data_i[8*k +: 8];
        #1;
    endtask

    task automatic rand_user();
        rd_addr_i = NRD*AW'($urandom);
        wr_addr_i = AW'($urandom);
        wr_data_i = WIDTH'($urandom);
        wr_en_i   = NB'($urandom);
    endtask

`ifdef F8_REGBANK_CTX_EN
    // Full spill (save=1) or refill; the sampling cycle's user inputs are set by the caller.
    task automatic run_seq(input bit save, input bit both, input logic [ADDR_W-1:0] base,
                           input int delay, input logic [WIDTH-1:0] r0,
                           input logic [WIDTH-1:0] r1, input logic [WIDTH-1:0] r2);
        logic [WIDTH-1:0] rdv [NREGS];
        rdv[0] = r0; rdv[1] = r1; rdv[2] = r2;
        ctx_save_i    = save | both;
        ctx_restore_i = !save | both;
        ctx_base_i    = base;
        mem_ack_i     = 0;
        exp_idle();
        cycle();
        ctx_save_i    = 0;
        ctx_restore_i = 0;
        ctx_base_i    = ADDR_W'($urandom);
        for (int i = 0; i < NREGS; i++) begin
            for (int w = 0; w <= delay; w++) begin
                exp_busy  = 1;
                exp_req   = 1;
                exp_addr  = base + ADDR_W'(i * NB);
                exp_we    = save ? {NB{1'b1}} : '0;
                exp_wdata = save ? model[i] : '0;
                mem_ack_i   = (w == delay);
                mem_rdata_i = (w == delay) ? rdv[i] : WIDTH'($urandom);
                ctx_save_i  = 1'($urandom);
                rand_user();
                cycle();
                if (!save && w == delay) model[i] = rdv[i];
            end
        end
        mem_ack_i  = 0;
        ctx_save_i = 0;
        wr_en_i    = '0;
        exp_idle();
        exp_done = 1;
        cycle();
        exp_done = 0;
        cycle();
    endtask
`endif

    initial begin
        rst_ni = 0; rd_addr_i = '0; wr_addr_i = '0; wr_data_i = '0; wr_en_i = '0;
        ctx_save_i = 0; ctx_restore_i = 0; ctx_base_i = '0; mem_rdata_i = '0; mem_ack_i = 0;
        for (int r = 0; r < NREGS; r++) model[r] = '0;
        exp_idle();

        rd_addr_i = {2'd2, 2'd1, 2'd0};
        cycle();
        rst_ni = 1;
        cycle();

        // Byte-lane write and forwarding.
        rd_addr_i = {2'd2, 2'd0, 2'd1};
        wr_addr_i = 2'd1; wr_data_i = 16'h0100; wr_en_i = 2'b11;
        cycle();
        wr_data_i = 16'hAA55; wr_en_i = 2'b01;
        #2;
        check("tp_lane_rd_next", rd_next_o[15:0], 16'h0155);
        cycle();
        wr_en_i = '0;
        #2;
        check("tp_lane_rd_data", port_data(0), 16'h0155);

        // Out-of-range register select on both read and write.
        rd_addr_i = {2'd3, 2'd3, 2'd3};
        wr_addr_i = 2'd3; wr_data_i = 16'hFFFF; wr_en_i = 2'b11;
        #2;
        check("tp_oor_rd_data", port_data(0), 16'h0000);
        check("tp_oor_rd_next", rd_next_o[15:0], 16'h0000);
        cycle();
        wr_en_i = '0;
        rd_addr_i = {2'd2, 2'd1, 2'd0};
        #2;
        check("tp_oor_reg1", port_data(1), 16'h0155);
        cycle();

        wr_addr_i = 2'd1; wr_data_i = 16'h0100; wr_en_i = 2'b11;
        cycle();
        wr_addr_i = 2'd2; wr_data_i = 16'hAA55; wr_en_i = 2'b11;
        cycle();

`ifdef F8_REGBANK_CTX_EN
        // Spill with wrap; reg0 is written in the sampling cycle and must be spilled.
        wr_addr_i = 2'd0; wr_data_i = 16'h0201; wr_en_i = 2'b11;
        rd_addr_i = {2'd2, 2'd1, 2'd0};
        run_seq(1, 0, 16'hFFFC, 0, '0, '0, '0);

        // Refill with delayed acks and dropped writes.
        wr_en_i = '0;
        run_seq(0, 0, 16'h2000, 2, 16'h1111, 16'h2222, 16'h3333);
        rd_addr_i = {2'd2, 2'd1, 2'd0};
        wr_en_i = '0;
        #2;
        check("tp_restore_r0", port_data(0), 16'h1111);
        check("tp_restore_r1", port_data(1), 16'h2222);
        check("tp_restore_r2", port_data(2), 16'h3333);
        cycle();

        // Simultaneous requests: save wins.
        run_seq(1, 1, 16'h0040, 1, '0, '0, '0);

        // Asynchronous reset in the middle of a spill.
        ctx_save_i = 1; ctx_base_i = 16'h1000; mem_ack_i = 0; wr_en_i = '0;
        rd_addr_i = {2'd2, 2'd1, 2'd0};
        exp_idle();
        cycle();
        ctx_save_i = 0;
        for (int i = 0; i < 2; i++) begin
            exp_busy = 1; exp_req = 1; exp_we = 2'b11;
            exp_addr = 16'h1000 + ADDR_W'(i * NB); exp_wdata = model[i];
            mem_ack_i = 1;
            cycle();
        end
        #2;
        rst_ni = 0;
        #1;
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_busy", ctx_busy_o, 1'b0);
        check("rst_reg0", port_data(0), 16'h0000);
        check("rst_reg2", port_data(2), 16'h0000);
        for (int r = 0; r < NREGS; r++) model[r] = '0;
        mem_ack_i = 0;
        @(posedge clk);
        #1;
        rst_ni = 1;
        wr_addr_i = 2'd2; wr_data_i = 16'h5A5A; wr_en_i = 2'b10;
        run_seq(1, 0, 16'h1000, 1, '0, '0, '0);
`else
        // No sequencer: requests are ignored and writes always land.
        for (int n = 0; n < 20; n++) begin
            ctx_save_i = 1'($urandom); ctx_restore_i = 1'($urandom);
            ctx_base_i = ADDR_W'($urandom); mem_ack_i = 1'($urandom);
            mem_rdata_i = WIDTH'($urandom);
            rand_user();
            cycle();
        end
        ctx_save_i = 0; ctx_restore_i = 0; mem_ack_i = 0;
`endif

        // Randomized traffic in the idle state.
        exp_idle();
        for (int n = 0; n < 200; n++) begin
            rand_user();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
